// File: rtl/station_pkg.sv
// rtl/station_pkg.sv - shared state encodings and iop field positions for station_array
package station_pkg;

  typedef logic [2:0] st_state_t;

  // Per-entry sequencer states; state[2]=1 marks a ready-to-issue state.
  localparam st_state_t ST_FREE   = 3'b000;
  localparam st_state_t ST_WAIT_1 = 3'b001;
  localparam st_state_t ST_WAIT_2 = 3'b010;
  localparam st_state_t ST_WAIT_3 = 3'b011;
  localparam st_state_t ST_LOAD_0 = 3'b100;
  localparam st_state_t ST_LOAD_1 = 3'b101;
  localparam st_state_t ST_ALU    = 3'b110;
  localparam st_state_t ST_STORE  = 3'b111;

  // iop word field indices
  localparam int IOP_WB  = 28;
  localparam int IOP_JSR = 23;
  localparam int IOP_RMW = 4;

endpackage

// File: rtl/station_age_matrix.sv
// rtl/station_age_matrix.sv - age matrix tracking allocation order; picks the oldest ready entry
module station_age_matrix #(
  parameter int DEPTH = 4,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] ready_i,
  output logic [DEPTH-1:0] oldest_o,
  output logic [TAG_W-1:0] oldest_tag_o
);

  // age_q[i][j]=1 means entry i was allocated before entry j.
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] blocked;

  // On allocation of entry k every other entry becomes older than k, and k older than none.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc_i[i]) age_q[i][j] <= 1'b0;
          else if (alloc_i[j]) age_q[i][j] <= 1'b1;
        end
      end
    end
  end

  // A ready entry is oldest when no other ready entry is older than it.
  always_comb begin
    blocked      = '0;
    oldest_o     = '0;
    oldest_tag_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready_i[j] && age_q[j][i]) blocked[i] = 1'b1;
      end
      if (ready_i[i] && !blocked[i]) begin
        oldest_o[i]  = 1'b1;
        oldest_tag_o = TAG_W'(i);
      end
    end
  end

endmodule

// File: rtl/station_array.sv
// rtl/station_array.sv - DEPTH-entry reservation station with tag writeback and oldest-ready issue; STATION_ARRAY_FLUSH_EN adds a flush input
module station_array
  import station_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              a_rst,
`ifdef STATION_ARRAY_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              id_feed,
  input  logic [31:0]       id_iop,
  input  logic [2:0]        id_iop_init,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_k16,
  output logic              id_full,
  output logic [TAG_W-1:0]  id_tag,
  input  logic              lsu_wb,
  input  logic [TAG_W-1:0]  lsu_tag,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              r_valid,
  output logic [TAG_W-1:0]  r_tag,
  output logic [2:0]        r_status,
  output logic [31:0]       r_iop,
  output logic [DATA_W-1:0] r_pc,
  output logic [DATA_W-1:0] r_k16,
  output logic              r_will_complete,
  output logic [DEPTH-1:0]  r_busy,
  input  logic              sched_ack
);

  logic              flush_w;
  logic              any_free;
  logic [TAG_W-1:0]  free_tag;
  logic              alloc_en;
  logic [DEPTH-1:0]  alloc_oh;
  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  oldest_oh;
  logic [DEPTH-1:0]  ack_oh;
  st_state_t         st_a  [DEPTH];
  logic [31:0]       iop_a [DEPTH];
  logic [DATA_W-1:0] pc_a  [DEPTH];
  logic [DATA_W-1:0] k16_a [DEPTH];

`ifdef STATION_ARRAY_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Lowest-index free entry, from registered state only, so an entry freed this cycle is not reused yet.
  always_comb begin
    any_free = 1'b0;
    free_tag = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        any_free = 1'b1;
        free_tag = TAG_W'(i);
      end
    end
  end

  assign id_full  = !any_free;
  assign id_tag   = free_tag;
  assign alloc_en = id_feed && any_free && (id_iop_init != ST_FREE) && !flush_w;
  assign ack_oh   = (sched_ack && r_valid) ? oldest_oh : '0;

  genvar g;
  for (g = 0; g < DEPTH; g++) begin : g_ent
    st_state_t         st_q, st_d;
    logic [31:0]       iop_q;
    logic [DATA_W-1:0] pc_q, k16_q, k16_d;
    logic              wb_hit, ack_hit;

    assign alloc_oh[g] = alloc_en && (free_tag == TAG_W'(g));
    assign wb_hit      = lsu_wb && (lsu_tag == TAG_W'(g));
    assign ack_hit     = ack_oh[g];
    assign ready[g]    = st_q[2];
    assign r_busy[g]   = (st_q != ST_FREE);
    assign st_a[g]     = st_q;
    assign iop_a[g]    = iop_q;
    assign pc_a[g]     = pc_q;
    assign k16_a[g]    = k16_q;

    // Entry sequencer next state and k16 update (allocation beats writeback for k16).
    always_comb begin
      st_d  = st_q;
      k16_d = k16_q;
      if (alloc_oh[g]) k16_d = id_k16;
      else if (wb_hit && st_q != ST_FREE) k16_d = lsu_data;
      if (flush_w) begin
        st_d = ST_FREE;
      end else begin
        case (st_q)
          ST_FREE:   if (alloc_oh[g]) st_d = id_iop_init;
          ST_WAIT_1: if (wb_hit) st_d = ST_LOAD_1;
          ST_WAIT_2: if (wb_hit) st_d = ST_ALU;
          ST_WAIT_3: st_d = ST_STORE;
          ST_LOAD_0: if (ack_hit) st_d = ST_WAIT_1;
          ST_LOAD_1: if (ack_hit) st_d = iop_q[IOP_WB] ? ST_FREE : ST_WAIT_2;
          ST_ALU:    if (ack_hit) st_d = iop_q[IOP_JSR] ? ST_STORE : ST_FREE;
          default:   if (ack_hit) st_d = ST_FREE;
        endcase
      end
    end

    // Entry registers; iop and pc are captured only on allocation.
    always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
        st_q  <= ST_FREE;
        iop_q <= '0;
        pc_q  <= '0;
        k16_q <= '0;
      end else begin
        st_q  <= st_d;
        k16_q <= k16_d;
        if (alloc_oh[g]) begin
          iop_q <= id_iop;
          pc_q  <= id_pc;
        end
      end
    end
  end

  station_age_matrix #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_age (
    .clk          (clk),
    .rst          (a_rst),
    .clr          (flush_w),
    .alloc_i      (alloc_oh),
    .ready_i      (ready),
    .oldest_o     (oldest_oh),
    .oldest_tag_o (r_tag)
  );

  assign r_valid  = |ready;
  assign r_status = st_a[r_tag];
  assign r_iop    = iop_a[r_tag];
  assign r_pc     = pc_a[r_tag];
  assign r_k16    = k16_a[r_tag];

  // Selected entry would leave to FREE if acked in this cycle.
  always_comb begin
    r_will_complete = 1'b0;
    case (r_status)
      ST_LOAD_1: r_will_complete = r_iop[IOP_WB];
      ST_ALU:    r_will_complete = !r_iop[IOP_JSR];
      ST_STORE:  r_will_complete = 1'b1;
      default:   r_will_complete = 1'b0;
    endcase
    if (!r_valid) r_will_complete = 1'b0;
  end

endmodule

// File: tb/tb_station_array.sv
// tb/tb_station_array.sv - directed scoreboard bench for station_array
module tb_station_array;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        flush;
  logic        id_feed;
  logic [31:0] id_iop;
  logic [2:0]  id_iop_init;
  logic [15:0] id_pc, id_k16;
  logic        id_full;
  logic [1:0]  id_tag;
  logic        lsu_wb;
  logic [1:0]  lsu_tag;
  logic [15:0] lsu_data;
  logic        r_valid;
  logic [1:0]  r_tag;
  logic [2:0]  r_status;
  logic [31:0] r_iop;
  logic [15:0] r_pc, r_k16;
  logic        r_will_complete;
  logic [3:0]  r_busy;
  logic        sched_ack;

  always #5 clk = ~clk;

  station_array #(.DEPTH(4), .DATA_W(16)) dut (
    .clk             (clk),
    .a_rst           (a_rst),
`ifdef STATION_ARRAY_FLUSH_EN
    .flush           (flush),
`endif
    .id_feed         (id_feed),
    .id_iop          (id_iop),
    .id_iop_init     (id_iop_init),
    .id_pc           (id_pc),
    .id_k16          (id_k16),
    .id_full         (id_full),
    .id_tag          (id_tag),
    .lsu_wb          (lsu_wb),
    .lsu_tag         (lsu_tag),
    .lsu_data        (lsu_data),
    .r_valid         (r_valid),
    .r_tag           (r_tag),
    .r_status        (r_status),
    .r_iop           (r_iop),
    .r_pc            (r_pc),
    .r_k16           (r_k16),
    .r_will_complete (r_will_complete),
    .r_busy          (r_busy),
    .sched_ack       (sched_ack)
  );

  localparam logic [2:0] S_WAIT_1 = 3'b001, S_WAIT_2 = 3'b010, S_WAIT_3 = 3'b011;
  localparam logic [2:0] S_LOAD_0 = 3'b100, S_LOAD_1 = 3'b101, S_ALU = 3'b110, S_STORE = 3'b111;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic ex(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic ck(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.name, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [2:0] init, input logic [31:0] iop, input logic [15:0] pc, input logic [15:0] k16);
    id_feed = 1'b1; id_iop_init = init; id_iop = iop; id_pc = pc; id_k16 = k16;
    tick();
    id_feed = 1'b0;
  endtask

  task automatic ack();
    sched_ack = 1'b1;
    tick();
    sched_ack = 1'b0;
  endtask

  task automatic wb(input logic [1:0] t, input logic [15:0] d);
    lsu_wb = 1'b1; lsu_tag = t; lsu_data = d;
    tick();
    lsu_wb = 1'b0;
  endtask

  task automatic do_reset();
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; flush = 1'b0; id_feed = 1'b0; id_iop = '0; id_iop_init = '0;
    id_pc = '0; id_k16 = '0; lsu_wb = 1'b0; lsu_tag = '0; lsu_data = '0; sched_ack = 1'b0;

    // reset values
    ex("rst_busy", 0); ex("rst_full", 0); ex("rst_id_tag", 0); ex("rst_valid", 0); ex("rst_r_tag", 0);
    ex("rst_status", 0); ex("rst_iop", 0); ex("rst_pc", 0); ex("rst_k16", 0); ex("rst_will", 0);
    tick();
    ck(r_busy); ck(id_full); ck(id_tag); ck(r_valid); ck(r_tag);
    ck(r_status); ck(r_iop); ck(r_pc); ck(r_k16); ck(r_will_complete);
    a_rst = 1'b0;

    // reset mid-operation
    for (int i = 0; i < 4; i++) feed(S_WAIT_1, 32'h10 + i, 16'h0 + 16'(i), 16'h0);
    ex("fill_busy", 4'hF); ex("fill_full", 1); ex("fill_valid", 0);
    ck(r_busy); ck(id_full); ck(r_valid);
    ex("mid_rst_busy", 0); ex("mid_rst_full", 0); ex("mid_rst_valid", 0); ex("mid_rst_id_tag", 0);
    do_reset();
    ck(r_busy); ck(id_full); ck(r_valid); ck(id_tag);

    // full / lowest-free allocation
    for (int i = 0; i < 3; i++) feed(S_ALU, 32'h0, 16'h1000 + 16'(i), 16'h0);
    ex("alloc_id_tag3", 3);
    ck(id_tag);
    feed(S_ALU, 32'h0, 16'h1003, 16'h0);
    ex("alloc_full", 1);
    ck(id_full);
    feed(S_ALU, 32'h0, 16'hDEAD, 16'h0);
    ex("fifth_busy", 4'hF); ex("fifth_r_tag", 0); ex("fifth_r_pc", 16'h1000);
    ck(r_busy); ck(r_tag); ck(r_pc);
    ack();
    ex("ack0_id_tag", 0); ex("ack0_r_tag", 1);
    ck(id_tag); ck(r_tag);
    ack();
    ex("ack1_r_tag", 2);
    ck(r_tag);
    feed(S_ALU, 32'h0, 16'h2000, 16'h0);
    feed(S_ALU, 32'h0, 16'h2001, 16'h0);
    ex("refill_full", 1); ex("refill_r_tag", 2); ex("refill_r_pc", 16'h1002);
    ck(id_full); ck(r_tag); ck(r_pc);
    ack();
    ex("ack2_id_tag", 2); ex("ack2_full", 0); ex("ack2_r_tag", 3);
    ck(id_tag); ck(id_full); ck(r_tag);

    // oldest-first selection with writebacks
    do_reset();
    for (int i = 0; i < 3; i++) feed(S_WAIT_1, 32'h0, 16'h3000 + 16'(i), 16'h0);
    ex("wb2_valid", 1); ex("wb2_r_tag", 2); ex("wb2_k16", 16'hBEEF); ex("wb2_status", S_LOAD_1);
    wb(2'd2, 16'hBEEF);
    ck(r_valid); ck(r_tag); ck(r_k16); ck(r_status);
    ex("wb0_r_tag", 0); ex("wb0_k16", 16'h0101); ex("wb0_status", S_LOAD_1);
    wb(2'd0, 16'h0101);
    ck(r_tag); ck(r_k16); ck(r_status);

    // load sequence
    do_reset();
    ex("ld_valid", 1); ex("ld_r_tag", 0); ex("ld_status", S_LOAD_0); ex("ld_pc", 16'h0100); ex("ld_k16", 16'h0007); ex("ld_will", 0);
    feed(S_LOAD_0, 32'h0, 16'h0100, 16'h0007);
    ck(r_valid); ck(r_tag); ck(r_status); ck(r_pc); ck(r_k16); ck(r_will_complete);
    ex("ld_ack1_valid", 0); ex("ld_ack1_busy", 4'h1);
    ack();
    ck(r_valid); ck(r_busy);
    ex("ld_wb1_status", S_LOAD_1); ex("ld_wb1_k16", 16'h1234); ex("ld_wb1_will", 0);
    wb(2'd0, 16'h1234);
    ck(r_status); ck(r_k16); ck(r_will_complete);
    ex("ld_ack2_valid", 0); ex("ld_ack2_busy", 4'h1);
    ack();
    ck(r_valid); ck(r_busy);
    ex("ld_wb2_status", S_ALU); ex("ld_wb2_k16", 16'h5678); ex("ld_wb2_will", 1);
    wb(2'd0, 16'h5678);
    ck(r_status); ck(r_k16); ck(r_will_complete);
    ex("ld_done_busy", 0); ex("ld_done_valid", 0);
    ack();
    ck(r_busy); ck(r_valid);

    // JSR path
    do_reset();
    ex("jsr_status", S_ALU); ex("jsr_will", 0);
    feed(S_ALU, 32'h0080_0000, 16'h0200, 16'h0);
    ck(r_status); ck(r_will_complete);
    ex("jsr_st_status", S_STORE); ex("jsr_st_will", 1); ex("jsr_st_valid", 1);
    ack();
    ck(r_status); ck(r_will_complete); ck(r_valid);
    ex("jsr_done_busy", 0); ex("jsr_done_valid", 0);
    ack();
    ck(r_busy); ck(r_valid);

    // simultaneous ack / wb / alloc
    do_reset();
    feed(S_WAIT_1, 32'h0, 16'h0010, 16'h0);
    feed(S_ALU,    32'h0, 16'h0011, 16'h0);
    feed(S_ALU,    32'h0, 16'h0012, 16'h0);
    feed(S_WAIT_2, 32'h0, 16'h0013, 16'h0);
    ex("sim_full", 1); ex("sim_r_tag", 1);
    ck(id_full); ck(r_tag);
    ack();
    ex("sim_ack1_r_tag", 2); ex("sim_ack1_id_tag", 1);
    ck(r_tag); ck(id_tag);
    sched_ack = 1'b1;
    feed(S_WAIT_3, 32'h0, 16'h0021, 16'h0);
    sched_ack = 1'b0;
    ex("sim_w3_valid", 0); ex("sim_w3_busy", 4'b1011); ex("sim_w3_id_tag", 2);
    ck(r_valid); ck(r_busy); ck(id_tag);
    ex("sim_st_r_tag", 1); ex("sim_st_status", S_STORE); ex("sim_st_will", 1);
    tick();
    ck(r_tag); ck(r_status); ck(r_will_complete);
    sched_ack = 1'b1; lsu_wb = 1'b1; lsu_tag = 2'd3; lsu_data = 16'hCAFE;
    ex("sim3_busy", 4'b1101); ex("sim3_id_tag", 1); ex("sim3_full", 0);
    ex("sim3_r_tag", 3); ex("sim3_status", S_ALU); ex("sim3_k16", 16'hCAFE);
    feed(S_LOAD_0, 32'h0, 16'h0ABC, 16'h0055);
    sched_ack = 1'b0; lsu_wb = 1'b0;
    ck(r_busy); ck(id_tag); ck(id_full); ck(r_tag); ck(r_status); ck(r_k16);
    ex("sim_last_r_tag", 2); ex("sim_last_status", S_LOAD_0); ex("sim_last_pc", 16'h0ABC); ex("sim_last_busy", 4'b0101);
    ack();
    ck(r_tag); ck(r_status); ck(r_pc); ck(r_busy);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
